// File: rtl/patch_column_feeder.sv
// patch_column_feeder
// Transmit side of the 56-bit patch-column stream. Buffers the previous six
// image rows of a raster-order 8-bit pixel stream in six rotating line
// buffers and, for each accepted pixel, emits the vertical 7-pixel column
// (rows y-6..y) at column x one cycle later.
//
// Optional feature macro: COL_FEEDER_ZERO_PAD_EN
//   defined   : every accepted pixel produces a column; byte lanes for rows
//               above the frame top are masked to zero.
//   undefined : columns are only produced once all seven rows belong to the
//               current frame (y >= 6); no padding logic exists.
module patch_column_feeder #(
    parameter int  WIDTH  = 640,
    parameter int  HEIGHT = 480,
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_pixel,
    input  logic          i_valid,
    input  logic          i_sof,
    output logic [55:0]   o_col,
    output logic          o_valid,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_eol,
    output logic          o_eof
);

    localparam int          NUM_SLOTS = 6;
    localparam logic [2:0]  LAST_SLOT = 3'd5;
    localparam logic [XW-1:0] LAST_X  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y  = YW'(HEIGHT - 1);

    // Six line buffers; slot p_eff holds the oldest row and is overwritten
    // by the current row, so the buffer never needs a separate copy step.
    logic [7:0] line_mem [0:NUM_SLOTS-1][0:WIDTH-1];

    logic [XW-1:0] x_cnt, x_eff, x_nxt;
    logic [YW-1:0] y_cnt, y_eff, y_nxt;
    logic [2:0]    p_cnt, p_eff, p_nxt;
    logic          last_x, last_y;
    logic          emit;
    logic [55:0]   col_next;

    // Maps "k-th oldest row" to its physical slot, rotating by the pointer.
    function automatic logic [2:0] slot_of(input logic [2:0] p, input int k);
        logic [3:0] s;
        s = {1'b0, p} + 4'(k);
        if (s >= 4'(NUM_SLOTS)) begin
            s = s - 4'(NUM_SLOTS);
        end
        return s[2:0];
    endfunction

    // Start-of-frame overrides the running position so the pixel lands at (0,0), slot 0.
    always_comb begin
        x_eff = x_cnt;
        y_eff = y_cnt;
        p_eff = p_cnt;
        if (i_sof) begin
            x_eff = '0;
            y_eff = '0;
            p_eff = '0;
        end
    end

    // Next raster position: advance column, roll rows and the slot pointer at end of line.
    always_comb begin
        last_x = (x_eff == LAST_X);
        last_y = (y_eff == LAST_Y);
        x_nxt  = x_eff + XW'(1);
        y_nxt  = y_eff;
        p_nxt  = p_eff;
        if (last_x) begin
            x_nxt = '0;
            if (last_y) begin
                y_nxt = '0;
                p_nxt = '0;
            end else begin
                y_nxt = y_eff + YW'(1);
                p_nxt = (p_eff == LAST_SLOT) ? 3'd0 : p_eff + 3'd1;
            end
        end
    end

    // Column assembly: buffered rows oldest-first in the low lanes, live pixel on top.
    always_comb begin
        col_next        = '0;
        col_next[55:48] = i_pixel;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            col_next[8*k +: 8] = line_mem[slot_of(p_eff, k)][x_eff];
`ifdef COL_FEEDER_ZERO_PAD_EN
            if (k < NUM_SLOTS - int'(y_eff)) begin
                col_next[8*k +: 8] = 8'h00;
            end
`endif
        end
    end

    // Decide whether this accepted pixel produces an output column.
    always_comb begin
`ifdef COL_FEEDER_ZERO_PAD_EN
        emit = 1'b1;
`else
        emit = (y_eff >= YW'(NUM_SLOTS));
`endif
    end

    // Line-buffer write into the oldest slot; reads above see the old contents this cycle.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            line_mem[p_eff][x_eff] <= i_pixel;
        end
    end

    // Raster counters and slot pointer; hold while no pixel is offered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            p_cnt <= '0;
        end else if (i_valid) begin
            x_cnt <= x_nxt;
            y_cnt <= y_nxt;
            p_cnt <= p_nxt;
        end
    end

    // Output register: one-cycle latency, data/coordinates hold between emitted columns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_col   <= '0;
            o_valid <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_eol   <= 1'b0;
            o_eof   <= 1'b0;
        end else begin
            o_valid <= i_valid && emit;
            if (i_valid && emit) begin
                o_col <= col_next;
                o_x   <= x_eff;
                o_y   <= y_eff;
                o_eol <= last_x;
                o_eof <= last_x && last_y;
            end else begin
                o_eol <= 1'b0;
                o_eof <= 1'b0;
            end
        end
    end

endmodule
